pass_through_byte_merge: RTL and testbench

- Sits directly downstream of the 8-bit masked pass-through stage. That stage drives only selected bit lanes of its output byte per cycle, e.g. bits [1:0] and [7:6].
- This block accumulates those partial bytes under a per-bit lane mask until every bit has been supplied, then queues the completed byte.
- A small FIFO delivers completed bytes over a valid/ready handshake to the consumer.

---
 rtl/pass_through_byte_merge_pkg.sv | 16 +
 rtl/pass_through_byte_merge_merge_sync_fifo.sv | 87 ++++++++
 rtl/pass_through_byte_merge.sv | 94 +++++++++
 tb/tb_pass_through_byte_merge.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pass_through_byte_merge_pkg.sv
// Shared types and constants for the pass-through byte merge block.
// Holds the FSM encoding, default sizing and the full-coverage mask.
package pass_through_byte_merge_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 3;

   localparam logic [WIDTH_DEF-1:0] ALL_ONES = {WIDTH_DEF{1'b1}};

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_PARTIAL = 1'b1
   } merge_state_e;

endpackage : pass_through_byte_merge_pkg

// File: rtl/pass_through_byte_merge_merge_sync_fifo.sv
// WIDTH x DEPTH synchronous FIFO with a registered head output.
// The head register holds its last value when the FIFO drains empty.
module merge_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_inc_s;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_push_s, do_pop_s;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == {CNT_W{1'b0}});
   assign count = count_q;
   assign rdata = rdata_q;

   // Next-state for pointers, occupancy, storage and the head register.
   always_comb begin
      do_push_s  = push && !full;
      do_pop_s   = pop && !empty;
      rptr_inc_s = rptr_q + PTR_ONE;
      mem_d      = mem_q;
      if (do_push_s) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      if (do_pop_s) begin
         rptr_d = rptr_inc_s;
      end else begin
         rptr_d = rptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // The head only changes when a new entry becomes the oldest one.
      if (do_push_s && (empty || (do_pop_s && (count_q == CNT_ONE)))) begin
         rdata_d = wdata;
      end else if (do_pop_s && (count_q > CNT_ONE)) begin
         rdata_d = mem_q[rptr_inc_s];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // FIFO state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wptr_q  <= {PTR_W{1'b0}};
         rptr_q  <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
         rdata_q <= {WIDTH{1'b0}};
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

endmodule : merge_sync_fifo

// File: rtl/pass_through_byte_merge.sv
// Accumulates lane-masked partial bytes until every bit is covered (or a
// flush arrives) and queues the result in a small output FIFO.
module pass_through_byte_merge
   import pass_through_byte_merge_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_mask,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output logic             overlap_err
);

   localparam logic [WIDTH-1:0] FULL_MASK = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] NO_BITS   = {WIDTH{1'b0}};

   logic [WIDTH-1:0] acc_q, acc_d, covered_q, covered_d;
   logic             overlap_err_q, overlap_err_d;
   merge_state_e     state_q, state_d;

   logic             fifo_full_s, fifo_empty_s, push_s, pop_s;
   logic             accept_s, complete_s, flush_take_s;
   logic [WIDTH-1:0] beat_mask_s, merged_s, cov_next_s, wdata_s;

   assign in_ready    = !fifo_full_s;
   assign out_valid   = !fifo_empty_s;
   assign pop_s       = out_valid && out_ready;
   assign overlap_err = overlap_err_q;

   // Merge datapath, completion/flush decision and FSM next state.
   always_comb begin
      accept_s      = in_valid && !fifo_full_s;
      beat_mask_s   = accept_s ? in_mask : NO_BITS;
      merged_s      = (acc_q & ~beat_mask_s) | (in_data & beat_mask_s);
      cov_next_s    = covered_q | beat_mask_s;
      complete_s    = accept_s && (cov_next_s == FULL_MASK);
      flush_take_s  = flush && !fifo_full_s && (cov_next_s != NO_BITS);
      push_s        = complete_s || flush_take_s;
      // Uncovered lanes are forced to zero on a flushed byte.
      wdata_s       = merged_s & cov_next_s;
      overlap_err_d = overlap_err_q | (accept_s && ((in_mask & covered_q) != NO_BITS));
      if (push_s) begin
         acc_d     = NO_BITS;
         covered_d = NO_BITS;
         state_d   = ST_EMPTY;
      end else begin
         acc_d     = merged_s;
         covered_d = cov_next_s;
         state_d   = (cov_next_s != NO_BITS) ? ST_PARTIAL : ST_EMPTY;
      end
   end

   // Accumulator, coverage, sticky error and FSM state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q         <= NO_BITS;
         covered_q     <= NO_BITS;
         overlap_err_q <= 1'b0;
         state_q       <= ST_EMPTY;
      end else begin
         acc_q         <= acc_d;
         covered_q     <= covered_d;
         overlap_err_q <= overlap_err_d;
         state_q       <= state_d;
      end
   end

   merge_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wdata_s),
      .rdata (out_data),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (count)
   );

endmodule : pass_through_byte_merge

// File: tb/tb_pass_through_byte_merge.sv
// Directed self-checking bench for pass_through_byte_merge.
module tb_pass_through_byte_merge;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [7:0] in_mask = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       flush = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] count;
   logic       overlap_err;

   int n_cmp = 0;
   int n_bad = 0;

   pass_through_byte_merge dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_mask     (in_mask),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .overlap_err (overlap_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic [7:0] m);
      in_data  = d;
      in_mask  = m;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_mask  = 8'h00;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);
      check("rst_overlap", 32'(overlap_err), 32'd0);
      rst = 1'b1;
      step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_state", 32'(dut.state_q), 32'd0);

      // Two-beat merge
      beat(8'hC3, 8'hC3);
      check("m2_valid_b1", 32'(out_valid), 32'd0);
      check("m2_state_b1", 32'(dut.state_q), 32'd1);
      beat(8'h18, 8'h3C);
      check("m2_valid", 32'(out_valid), 32'd1);
      check("m2_data", 32'(out_data), 32'hDB);
      check("m2_overlap", 32'(overlap_err), 32'd0);
      check("m2_state", 32'(dut.state_q), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("m2_pop_count", 32'(count), 32'd0);
      check("m2_hold_data", 32'(out_data), 32'hDB);

      // Zero-mask beat is accepted without effect
      beat(8'hFF, 8'h00);
      check("zm_state", 32'(dut.state_q), 32'd0);
      check("zm_count", 32'(count), 32'd0);
      check("zm_overlap", 32'(overlap_err), 32'd0);

      // Overlap
      beat(8'h01, 8'h03);
      check("ov_err_b1", 32'(overlap_err), 32'd0);
      beat(8'h0E, 8'h0F);
      check("ov_err_b2", 32'(overlap_err), 32'd1);
      beat(8'hA0, 8'hF0);
      check("ov_data", 32'(out_data), 32'hAE);
      check("ov_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Flush partial
      beat(8'h80, 8'hC0);
      check("fl_state_pre", 32'(dut.state_q), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_data", 32'(out_data), 32'h80);
      check("fl_count", 32'(count), 32'd1);
      check("fl_state", 32'(dut.state_q), 32'd0);
      step();
      check("fl_noop_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Flush together with a beat from EMPTY
      in_data = 8'hF5; in_mask = 8'h0F; in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0; in_mask = 8'h00;
      check("flb_data", 32'(out_data), 32'h05);
      check("flb_state", 32'(dut.state_q), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("flb_count", 32'(count), 32'd0);

      // Backpressure
      beat(8'h11, 8'hFF);
      beat(8'h22, 8'hFF);
      beat(8'h33, 8'hFF);
      beat(8'h44, 8'hFF);
      check("bp_count", 32'(count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_head", 32'(out_data), 32'h11);
      in_data = 8'h55; in_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; in_mask = 8'h00;
      check("bp_refuse_count", 32'(count), 32'd3);
      check("bp_d22", 32'(out_data), 32'h22);
      step();
      check("bp_d33", 32'(out_data), 32'h33);
      step();
      check("bp_d44", 32'(out_data), 32'h44);
      step();
      check("bp_empty", 32'(out_valid), 32'd0);
      check("bp_state", 32'(dut.state_q), 32'd0);

      // Wrap with continuous drain
      for (int i = 1; i <= 6; i++) begin
         beat(8'(i * 17), 8'hFF);
         check("wr_data", 32'(out_data), 32'(i * 17));
         check("wr_count", 32'(count), 32'd1);
      end
      step();
      check("wr_drained", 32'(count), 32'd0);
      out_ready = 1'b0;

      // Async reset mid-PARTIAL with two entries queued
      beat(8'hA1, 8'hFF);
      beat(8'hA2, 8'hFF);
      beat(8'h03, 8'h03);
      beat(8'h0C, 8'h06);
      check("ar_pre_count", 32'(count), 32'd2);
      check("ar_pre_state", 32'(dut.state_q), 32'd1);
      check("ar_pre_overlap", 32'(overlap_err), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_count", 32'(count), 32'd0);
      check("ar_overlap", 32'(overlap_err), 32'd0);
      check("ar_state", 32'(dut.state_q), 32'd0);
      #3;
      rst = 1'b1;
      step();
      check("ar_in_ready", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pass_through_byte_merge
